// File: rtl/valid_ready_reorder_sequencer_pkg.sv
// Shared constants for the reorder sequencer.
package valid_ready_reorder_sequencer_pkg;
    // Reset value of the registered error flags (output_error, protocol_error)
    localparam logic ERR_FLAG_RST = 1'b0;
endpackage

// File: rtl/reorder_sequencer_order_queue.sv
// Circular FIFO of buffer indices in allocation order.
// The pointers carry an extra wrap bit, so full and empty are told apart without a counter.
// The caller must not push when full and must not pop when empty.
module reorder_sequencer_order_queue
    import valid_ready_reorder_sequencer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic                   pop,
    output logic [INDEX_WIDTH-1:0] head_index,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] count
);
    localparam int PW = INDEX_WIDTH + 1;

    logic [INDEX_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    assign head_index = mem[rd_ptr[INDEX_WIDTH-1:0]];
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[INDEX_WIDTH] != rd_ptr[INDEX_WIDTH]) &&
                        (wr_ptr[INDEX_WIDTH-1:0] == rd_ptr[INDEX_WIDTH-1:0]);
    assign count      = COUNT_WIDTH'(wr_ptr - rd_ptr);

    // Pointer advance and index storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[INDEX_WIDTH-1:0]] <= push_index;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end
endmodule

// File: rtl/valid_ready_reorder_sequencer.sv
// Reorder sequencer: records buffer indices in allocation order, collects out-of-order
// completions in a bitmap, and issues read-and-clear requests to the buffer strictly
// in allocation order, re-emitting the data on an in-order valid/ready stream.
// Optional feature: VALID_READY_REORDER_SEQUENCER_PROTOCOL_CHECK_EN builds a per-index
// in-queue bitmap and a sticky protocol_error flag for duplicate or stray completions.
module valid_ready_reorder_sequencer
    import valid_ready_reorder_sequencer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   allocate_valid,
    input  logic [INDEX_WIDTH-1:0] allocate_index,
    output logic                   allocate_ready,
    input  logic                   complete_valid,
    input  logic [INDEX_WIDTH-1:0] complete_index,
    output logic                   buffer_read_valid,
    output logic                   buffer_read_clear,
    output logic [INDEX_WIDTH-1:0] buffer_read_index,
    input  logic [WIDTH-1:0]       buffer_read_data,
    input  logic                   buffer_read_error,
    output logic                   output_valid,
    output logic [WIDTH-1:0]       output_data,
    output logic                   output_error,
    input  logic                   output_ready,
    output logic [COUNT_WIDTH-1:0] pending_count,
    output logic                   protocol_error
);
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   issue;
    logic [INDEX_WIDTH-1:0] head_index;
    logic [DEPTH-1:0]       done_bits;
    logic [DEPTH-1:0]       done_next;

    // Full blocks allocation even when an issue pops in the same cycle
    assign push           = allocate_valid & ~full;
    assign allocate_ready = ~full;

    // Issue only when the head has completed and the output register is free or draining
    assign issue             = ~empty & done_bits[head_index] & (~output_valid | output_ready);
    assign buffer_read_valid = issue;
    assign buffer_read_clear = issue;
    assign buffer_read_index = head_index;

    reorder_sequencer_order_queue #(
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_order_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_index (allocate_index),
        .pop        (issue),
        .head_index (head_index),
        .full       (full),
        .empty      (empty),
        .count      (pending_count)
    );

    // Completion bitmap next state: clear the issued head, then set the completed index (set wins)
    always_comb begin
        done_next = done_bits;
        if (issue)          done_next[head_index]     = 1'b0;
        if (complete_valid) done_next[complete_index] = 1'b1;
    end

    // Completion bitmap register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) done_bits <= '0;
        else       done_bits <= done_next;
    end

    // Output register: capture buffer data on issue, drop valid once accepted with nothing behind it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            output_valid <= 1'b0;
            output_data  <= '0;
            output_error <= ERR_FLAG_RST;
        end else if (issue) begin
            output_valid <= 1'b1;
            output_data  <= buffer_read_data;
            output_error <= buffer_read_error;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

`ifdef VALID_READY_REORDER_SEQUENCER_PROTOCOL_CHECK_EN
    logic [DEPTH-1:0] in_queue;
    logic [DEPTH-1:0] in_queue_next;
    logic             perr;

    // Which indices are currently held in the order queue
    always_comb begin
        in_queue_next = in_queue;
        if (issue) in_queue_next[head_index]     = 1'b0;
        if (push)  in_queue_next[allocate_index] = 1'b1;
    end

    // In-queue bitmap register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) in_queue <= '0;
        else       in_queue <= in_queue_next;
    end

    // Sticky flag for a duplicate completion or a completion of an index not in the queue
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            perr <= ERR_FLAG_RST;
        else if (complete_valid & (done_bits[complete_index] | ~in_queue[complete_index]))
            perr <= 1'b1;
    end

    assign protocol_error = perr;
`else
    assign protocol_error = 1'b0;
`endif
endmodule
